// File: rtl/md_scheduler.sv
// md_scheduler: HI/LO multiply/divide sequencer for the E stage.
// It latches operands at launch and holds busy for a fixed latency.
// The result is committed to HI/LO on the last busy edge.
// It also raises the D-stage stall for MD-class instructions while the unit is occupied.
module md_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDop,
  input  logic        HIwrite,
  input  logic        LOwrite,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_MD_yes,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        stall
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MSUB  = 3'b100;

  // The counter is loaded with latency-1, so a latency of N gives N busy cycles.
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        op_valid;
  logic        op_is_div;
  logic        commit;
  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  // State register and datapath registers; reset clears everything, including any in-flight result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Next-state: launch from IDLE on a valid op, count down in BUSY, return to IDLE after the last cycle.
  always_comb begin
    // NOTE: every variable gets a default here first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    op_valid  = (MDop <= OP_MSUB);
    op_is_div = (MDop == OP_DIVU) || (MDop == OP_DIV);
    case (state_q)
      IDLE: begin
        if (start && op_valid) begin
          state_d = BUSY;
          cnt_d   = op_is_div ? DIV_LOAD : MULT_LOAD;
          a_d     = A;
          b_d     = B;
          op_d    = MDop;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = IDLE;
      end
    endcase
  end

  // Arithmetic on the latched operands.
  // Signed division runs on magnitudes, then the quotient and remainder signs are fixed up.
  always_comb begin
    prod_u  = {32'd0, a_q} * {32'd0, b_q};
    prod_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    a_neg   = (op_q == OP_DIV) && a_q[31];
    b_neg   = (op_q == OP_DIV) && b_q[31];
    mag_a   = a_neg ? (~a_q + 32'd1) : a_q;
    mag_b   = b_neg ? (~b_q + 32'd1) : b_q;
    // A zero divisor never commits; substituting 1 keeps the divider well defined.
    divisor = (b_q == 32'd0) ? 32'd1 : mag_b;
    quo_mag = mag_a / divisor;
    rem_mag = mag_a % divisor;
    quo     = (a_neg ^ b_neg) ? (~quo_mag + 32'd1) : quo_mag;
    rem     = a_neg ? (~rem_mag + 32'd1) : rem_mag;
  end

  // HI/LO next value: mthi/mtlo only in IDLE without a launch, and the result on the final busy edge.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    commit = (state_q == BUSY) && (cnt_q == 4'd0);
    if ((state_q == IDLE) && !start) begin
      if (HIwrite) hi_d = A;
      if (LOwrite) lo_d = A;
    end
    if (commit) begin
      case (op_q)
        OP_MULTU: {hi_d, lo_d} = prod_u;
        OP_MULT:  {hi_d, lo_d} = prod_s;
        OP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
        OP_DIVU, OP_DIV: begin
          if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: busy comes straight from the state flop; stall is combinational on the D-stage request.
  always_comb begin
    busy  = (state_q == BUSY);
    stall = D_MD_yes && (start || busy);
    HI    = hi_q;
    LO    = lo_q;
  end

endmodule
